// File: rtl/miss_counter_pkg.sv
// Shared cache/perf-monitor definitions: default miss counter width and its
// saturation value.
package miss_counter_pkg;

    localparam int MISS_CNT_WIDTH = 16;
    localparam logic [MISS_CNT_WIDTH-1:0] MISS_CNT_MAX = '1;

endpackage : miss_counter_pkg

// File: rtl/miss_counter_sat_incr.sv
// Combinational saturating incrementer: adds one when enabled unless the value
// is already all-ones; flags when the resulting value sits at all-ones.
module sat_incr
    import miss_counter_pkg::*;
#(
    parameter int WIDTH = MISS_CNT_WIDTH
) (
    input  logic [WIDTH-1:0] value,
    input  logic             enable,
    output logic [WIDTH-1:0] next_value,
    output logic             at_max
);

    localparam logic [WIDTH-1:0] MAX = '1;

    logic value_at_max;

    // The explicit all-ones guard means the WIDTH-bit add can never wrap.
    assign value_at_max = (value == MAX);
    assign next_value   = (enable && !value_at_max) ? value + WIDTH'(1) : value;
    assign at_max       = (next_value == MAX);

endmodule : sat_incr

// File: rtl/miss_counter.sv
// Saturating cache-miss event counter: counts every clock with MISS high and
// holds a sticky flag once the count reaches all-ones.
module miss_counter
    import miss_counter_pkg::*;
#(
    parameter int WIDTH = MISS_CNT_WIDTH
) (
    input  logic             CLOCK,
    input  logic             INIT,
    input  logic             MISS,
    output logic [WIDTH-1:0] MISSES,
    output logic             MISS_SAT
);

    logic [WIDTH-1:0] count_next;
    logic             next_at_max;

    sat_incr #(
        .WIDTH (WIDTH)
    ) u_sat_incr (
        .value      (MISSES),
        .enable     (MISS),
        .next_value (count_next),
        .at_max     (next_at_max)
    );

    // Flag rises in the same edge that loads all-ones and is held until INIT.
    always_ff @(posedge CLOCK or posedge INIT) begin
        if (INIT) begin
            MISSES   <= '0;
            MISS_SAT <= 1'b0;
        end else begin
            MISSES   <= count_next;
            MISS_SAT <= MISS_SAT | next_at_max;
        end
    end

endmodule : miss_counter

// File: tb/tb_miss_counter.sv
// Scoreboard bench for miss_counter: a default-width and a 4-bit instance share
// the same stimulus and are compared against independent reference counters.
module tb_miss_counter;

    logic        CLOCK;
    logic        INIT;
    logic        MISS;
    logic [15:0] misses_16;
    logic        sat_16;
    logic [3:0]  misses_4;
    logic        sat_4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int unsigned cnt16;
        bit          sat16;
        int unsigned cnt4;
        bit          sat4;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned ref16;
    int unsigned ref4;
    bit          rsat16;
    bit          rsat4;

    miss_counter u_dut16 (
        .CLOCK    (CLOCK),
        .INIT     (INIT),
        .MISS     (MISS),
        .MISSES   (misses_16),
        .MISS_SAT (sat_16)
    );

    miss_counter #(.WIDTH(4)) u_dut4 (
        .CLOCK    (CLOCK),
        .INIT     (INIT),
        .MISS     (MISS),
        .MISSES   (misses_4),
        .MISS_SAT (sat_4)
    );

    initial begin
        CLOCK = 1'b0;
        #10;
        forever begin
            CLOCK = 1'b1;
            #5;
            CLOCK = 1'b0;
            #5;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_cleared(input string tag);
        check_val({tag, "_cnt16"}, 32'(misses_16), 32'd0);
        check_val({tag, "_sat16"}, 32'(sat_16), 32'd0);
        check_val({tag, "_cnt4"}, 32'(misses_4), 32'd0);
        check_val({tag, "_sat4"}, 32'(sat_4), 32'd0);
    endtask

    task automatic model_reset();
        ref16  = 0;
        ref4   = 0;
        rsat16 = 1'b0;
        rsat4  = 1'b0;
    endtask

    // Called 1 ns after an edge: pulses INIT between edges with MISS unknown.
    task automatic do_reset(input string tag);
        #3;
        INIT = 1'b1;
        MISS = 1'bx;
        #1;
        model_reset();
        check_cleared({tag, "_async"});
        @(posedge CLOCK);
        #1;
        check_cleared({tag, "_hold"});
        #4;
        INIT = 1'b0;
        MISS = 1'b0;
    endtask

    // Drive one MISS value for the next edge, push its expectation, then compare.
    task automatic step(input bit m, input string tag);
        exp_t e;
        exp_t got;
        MISS = m;
        if (m) begin
            if (ref16 < 32'hFFFF) ref16++;
            if (ref4 < 15) ref4++;
        end
        rsat16 = rsat16 | (ref16 == 32'hFFFF);
        rsat4  = rsat4 | (ref4 == 15);
        e.cnt16 = ref16;
        e.sat16 = rsat16;
        e.cnt4  = ref4;
        e.sat4  = rsat4;
        sb_q.push_back(e);
        @(posedge CLOCK);
        #1;
        if (sb_q.size() == 0) begin
            check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            got = sb_q.pop_front();
            check_val({tag, "_cnt16"}, 32'(misses_16), got.cnt16);
            check_val({tag, "_sat16"}, 32'(sat_16), 32'(got.sat16));
            check_val({tag, "_cnt4"}, 32'(misses_4), got.cnt4);
            check_val({tag, "_sat4"}, 32'(sat_4), 32'(got.sat4));
        end
    endtask

    initial begin
        bit pat_a [6] = '{0, 0, 1, 0, 1, 1};
        INIT = 1'b0;
        MISS = 1'bx;
        model_reset();
        #12;
        do_reset("rst0");

        for (int i = 0; i < 6; i++) step(pat_a[i], $sformatf("idle%0d", i));

        do_reset("rst1");
        for (int i = 0; i < 10; i++) step(1'b1, $sformatf("held%0d", i));

        for (int i = 10; i < 20; i++) step(1'b1, $sformatf("sat%0d", i));
        step(1'b0, "sat_idle");

        do_reset("rst_sat");
        step(1'b1, "resume0");
        step(1'b0, "resume1");
        step(1'b1, "resume2");

        do_reset("rst2");
        for (int i = 0; i < 7; i++) step(1'b1, $sformatf("pre%0d", i));
        check_val("pre_cnt16", 32'(misses_16), 32'd7);
        MISS = 1'b1;
        @(posedge CLOCK);
        INIT = 1'b1;
        #1;
        model_reset();
        check_cleared("mid_edge");
        @(posedge CLOCK);
        #1;
        check_cleared("mid_hold");
        #4;
        INIT = 1'b0;
        MISS = 1'b0;
        step(1'b1, "post_mid");

        check_val("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_miss_counter
